// File: rtl/rf_dump_reader.sv
// Debug read-out engine: walks the register file through one read port and streams
// (address, data) snapshots to a valid/ready consumer, bypassing same-edge writes.
module rf_dump_reader #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    parameter bit          SKIP_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              dump_req,
    input  logic              dump_abort,
    output logic [ADDR_W-1:0] rf_out_ra,
    input  logic [DATA_W-1:0] rf_in_rd,
    input  logic              rf_in_wre,
    input  logic [ADDR_W-1:0] rf_in_wa,
    input  logic [DATA_W-1:0] rf_in_wd,
    output logic              dmp_valid,
    input  logic              dmp_ready,
    output logic [ADDR_W-1:0] dmp_addr,
    output logic [DATA_W-1:0] dmp_data,
    output logic              dmp_last,
    output logic              dump_busy,
    output logic              dump_done,
    output logic              wr_during_dump
);

    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(31);
    localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(SKIP_R0 ? 1 : 0);

    typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              bypass;

    // A write landing on the capture edge wins over the stale read data.
    assign bypass    = rf_in_wre && (rf_in_wa == addr_q) && (addr_q != '0);
    assign rf_out_ra = (state_q == StIdle) ? '0 : addr_q;
    assign dump_busy = (state_q != StIdle);
    assign dump_done = (state_q == StDone);
    assign dmp_last  = dmp_valid && (dmp_addr == LastAddr);

    always_ff @(posedge clk) begin
        if (rst_l) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            dmp_valid      <= 1'b0;
            dmp_addr       <= '0;
            dmp_data       <= '0;
            wr_during_dump <= 1'b0;
        end else begin
            if (dump_busy && rf_in_wre && (rf_in_wa != '0)) begin
                wr_during_dump <= 1'b1;
            end
            // Abort beats the handshake: an entry accepted in the same cycle is dropped.
            if ((state_q != StIdle) && dump_abort) begin
                state_q   <= StIdle;
                dmp_valid <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (dump_req) begin
                            addr_q         <= FirstAddr;
                            wr_during_dump <= 1'b0;
                            state_q        <= StRead;
                        end
                    end
                    StRead: begin
                        dmp_data  <= bypass ? rf_in_wd : rf_in_rd;
                        dmp_addr  <= addr_q;
                        dmp_valid <= 1'b1;
                        state_q   <= StSend;
                    end
                    StSend: begin
                        if (dmp_ready) begin
                            dmp_valid <= 1'b0;
                            if (addr_q == LastAddr) begin
                                state_q <= StDone;
                            end else begin
                                addr_q  <= addr_q + 1'b1;
                                state_q <= StRead;
                            end
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Bench for rf_dump_reader: a behavioural register file plus a dump-level model of which
// entries must appear, with what data, at which cycle.
module tb_rf_dump_reader;

    logic        clk = 1'b0;
    logic        rst_l, dump_req, dump_abort;
    logic [4:0]  rf_out_ra;
    logic [31:0] rf_in_rd;
    logic        rf_in_wre;
    logic [4:0]  rf_in_wa;
    logic [31:0] rf_in_wd;
    logic        dmp_valid, dmp_ready;
    logic [4:0]  dmp_addr;
    logic [31:0] dmp_data;
    logic        dmp_last, dump_busy, dump_done, wr_during_dump;

    logic [31:0] rf_mem [32];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          exp_wr = 1'b0;

    always #5 clk = ~clk;

    rf_dump_reader dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .dump_req       (dump_req),
        .dump_abort     (dump_abort),
        .rf_out_ra      (rf_out_ra),
        .rf_in_rd       (rf_in_rd),
        .rf_in_wre      (rf_in_wre),
        .rf_in_wa       (rf_in_wa),
        .rf_in_wd       (rf_in_wd),
        .dmp_valid      (dmp_valid),
        .dmp_ready      (dmp_ready),
        .dmp_addr       (dmp_addr),
        .dmp_data       (dmp_data),
        .dmp_last       (dmp_last),
        .dump_busy      (dump_busy),
        .dump_done      (dump_done),
        .wr_during_dump (wr_during_dump)
    );

    // Behavioural register file: r0 reads zero, writes land on the rising edge.
    assign rf_in_rd = (rf_out_ra == 5'd0) ? 32'd0 : rf_mem[rf_out_ra];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_in_wre && rf_in_wa != 5'd0) rf_mem[rf_in_wa] <= rf_in_wd;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_wr(input int a, input logic [31:0] d);
        rf_in_wre = 1'b1;
        rf_in_wa  = 5'(a);
        rf_in_wd  = d;
        if (a != 0) exp_wr = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, 64'(dmp_valid), 64'(0));
        chk({tag, "_addr"}, 64'(dmp_addr), 64'(0));
        chk({tag, "_data"}, 64'(dmp_data), 64'(0));
        chk({tag, "_last"}, 64'(dmp_last), 64'(0));
        chk({tag, "_busy"}, 64'(dump_busy), 64'(0));
        chk({tag, "_done"}, 64'(dump_done), 64'(0));
        chk({tag, "_wr"}, 64'(wr_during_dump), 64'(0));
        chk({tag, "_ra"}, 64'(rf_out_ra), 64'(0));
    endtask

    // Load r1..r31 through the write port while idle; rnd=0 gives 0x1000_0000+N.
    task automatic preload(input bit rnd);
        for (int a = 1; a < 32; a++) begin
            rf_in_wre = 1'b1;
            rf_in_wa  = 5'(a);
            rf_in_wd  = rnd ? $urandom : 32'h1000_0000 + 32'(a);
            step();
        end
        rf_in_wre = 1'b0;
    endtask

    // One dump of r1..r31. Knobs are register numbers (-1 = unused): stall that entry,
    // write it in its READ cycle, write it while it is held, pulse dump_req, write r0,
    // abort or reset while it is presented. rnd adds random writes and backpressure.
    task automatic run_dump(input int stall_addr, input int stall_n, input int wr_read_addr,
                            input logic [31:0] wr_read_val, input int wr_send_addr,
                            input int req_addr, input int r0_addr, input int abort_addr,
                            input int rst_addr, input bit rnd);
        int          t0;
        int          stalls;
        int          ns;
        logic [31:0] exp_d;
        stalls   = 0;
        exp_wr   = 1'b0;
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        t0 = cyc;
        chk("busy_after_req", 64'(dump_busy), 64'(1));
        chk("valid_after_req", 64'(dmp_valid), 64'(0));
        for (int r = 1; r <= 31; r++) begin
            chk("read_ra", 64'(rf_out_ra), 64'(r));
            if (r == wr_read_addr) drive_wr(r, wr_read_val);
            else if (rnd && $urandom_range(0, 3) == 0) drive_wr($urandom_range(0, 31), $urandom);
            if (r == r0_addr) drive_wr(0, $urandom);
            if (r == req_addr) dump_req = 1'b1;
            step();
            rf_in_wre = 1'b0;
            dump_req  = 1'b0;
            exp_d = rf_mem[r];
            chk("entry_valid", 64'(dmp_valid), 64'(1));
            chk("entry_addr", 64'(dmp_addr), 64'(r));
            chk("entry_data", 64'(dmp_data), 64'(exp_d));
            chk("entry_last", 64'(dmp_last), 64'(r == 31));
            chk("entry_cycle", 64'(cyc), 64'(t0 + 2 * (r - 1) + 1 + stalls));
            chk("entry_no_done", 64'(dump_done), 64'(0));
            if (r == wr_read_addr) chk("bypass_data", 64'(dmp_data), 64'(wr_read_val));
            if (r == rst_addr) begin
                rst_l = 1'b1;
                step();
                rst_l  = 1'b0;
                exp_wr = 1'b0;
                check_reset("rst_mid");
                return;
            end
            if (r == abort_addr) begin
                dmp_ready  = 1'b1;
                dump_abort = 1'b1;
                step();
                dump_abort = 1'b0;
                chk("abort_valid", 64'(dmp_valid), 64'(0));
                chk("abort_busy", 64'(dump_busy), 64'(0));
                chk("abort_done", 64'(dump_done), 64'(0));
                chk("abort_wr", 64'(wr_during_dump), 64'(exp_wr));
                step();
                chk("abort_done_late", 64'(dump_done), 64'(0));
                chk("abort_idle", 64'(dump_busy), 64'(0));
                return;
            end
            ns = (r == stall_addr) ? stall_n : (rnd ? $urandom_range(0, 2) : 0);
            if (r == wr_send_addr) drive_wr(r, ~exp_d);
            dmp_ready = (ns == 0);
            for (int s = 0; s < ns; s++) begin
                step();
                rf_in_wre = 1'b0;
                chk("hold_valid", 64'(dmp_valid), 64'(1));
                chk("hold_addr", 64'(dmp_addr), 64'(r));
                chk("hold_data", 64'(dmp_data), 64'(exp_d));
                chk("hold_ra", 64'(rf_out_ra), 64'(r));
            end
            stalls += ns;
            dmp_ready = 1'b1;
            step();
            rf_in_wre = 1'b0;
            chk("accepted_valid", 64'(dmp_valid), 64'(0));
        end
        chk("done_pulse", 64'(dump_done), 64'(1));
        chk("done_busy", 64'(dump_busy), 64'(1));
        chk("done_cycle", 64'(cyc), 64'(t0 + 62 + stalls));
        step();
        chk("done_cleared", 64'(dump_done), 64'(0));
        chk("idle_busy", 64'(dump_busy), 64'(0));
        chk("idle_ra", 64'(rf_out_ra), 64'(0));
        chk("wr_flag", 64'(wr_during_dump), 64'(exp_wr));
    endtask

    initial begin
        rst_l      = 1'b1;
        dump_req   = 1'b0;
        dump_abort = 1'b0;
        rf_in_wre  = 1'b0;
        rf_in_wa   = 5'd0;
        rf_in_wd   = 32'd0;
        dmp_ready  = 1'b1;
        @(negedge clk);
        step();
        step();
        check_reset("por");
        rst_l = 1'b0;
        step();

        // Full dump with the ramp pattern, then backpressure on r5 for 3 cycles.
        preload(1'b0);
        run_dump(-1, 0, -1, 32'd0, -1, -1, -1, -1, -1, 1'b0);
        run_dump(5, 3, -1, 32'd0, -1, -1, -1, -1, -1, 1'b0);

        // Same-edge bypass on r7, write during a held r3.
        preload(1'b1);
        run_dump(3, 2, 7, 32'hDEAD_BEEF, 3, -1, -1, -1, -1, 1'b0);

        // Abort on r10 after a write to r4, then a fresh dump restarting at r1.
        run_dump(-1, 0, 4, $urandom, -1, -1, -1, 10, -1, 1'b0);
        run_dump(-1, 0, -1, 32'd0, -1, -1, -1, -1, -1, 1'b0);

        // Ignored mid-dump request and an r0 write: flag must stay clear.
        run_dump(-1, 0, -1, 32'd0, -1, 12, 15, -1, -1, 1'b0);

        // Reset while r20 is presented, then randomized dumps.
        run_dump(-1, 0, -1, 32'd0, -1, -1, -1, -1, 20, 1'b0);
        preload(1'b1);
        for (int i = 0; i < 3; i++) run_dump(-1, 0, -1, 32'd0, -1, -1, -1, -1, -1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_dump_reader.md
# rf_dump_reader

Debug read-out engine for the MIPS register file. On request it walks the register file through one read port, captures each register into an output buffer, and streams (address, data) pairs to a debug consumer under a valid/ready handshake. It sits beside the register file, sharing one read port and snooping the write port, so a dump taken while the core runs returns each register's most recent value at capture time.

## Interface
Parameters:
- ADDR_W, 5, register address width (32 registers)
- DATA_W, 32, register data width
- SKIP_R0, 1, when 1 the dump starts at r1 (r0 is hardwired zero)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_l  in  1  reset, synchronous, active-high
- dump_req  in  1  start a dump; sampled only in IDLE
- dump_abort  in  1  terminate a dump in progress
- rf_out_ra  out  ADDR_W  read address driven to the register-file read port
- rf_in_rd  in  DATA_W  combinational read data returned for rf_out_ra
- rf_in_wre  in  1  register-file write enable (snooped)
- rf_in_wa  in  ADDR_W  register-file write address (snooped)
- rf_in_wd  in  DATA_W  register-file write data (snooped)
- dmp_valid  out  1  output entry valid
- dmp_ready  in  1  consumer accepts entry
- dmp_addr  out  ADDR_W  register number of current entry
- dmp_data  out  DATA_W  register value of current entry
- dmp_last  out  1  current entry is r31
- dump_busy  out  1  state is not IDLE
- dump_done  out  1  one-cycle pulse after last entry accepted
- wr_during_dump  out  1  sticky: a non-r0 write occurred while busy

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: rf_out_ra=0. On dump_req: addr <= (SKIP_R0 ? 1 : 0), wr_during_dump <= 0, go READ.
- READ: rf_out_ra=addr. At the edge, dmp_data <= rf_in_rd, dmp_addr <= addr, dmp_valid <= 1, go SEND.
- Write bypass in READ: if rf_in_wre and rf_in_wa==addr and addr!=0, capture rf_in_wd instead of rf_in_rd. A write landing in the same edge is therefore never lost.
- SEND: rf_out_ra=addr. dmp_data/dmp_addr are held stable while dmp_valid and !dmp_ready. Writes after capture do not alter the held entry (snapshot semantics). On dmp_valid&&dmp_ready: dmp_valid <= 0. If addr==31, go DONE; else addr <= addr+1, go READ.
- dmp_last = dmp_valid && dmp_addr==31.
- DONE: dump_done=1 for this cycle only, go IDLE.
- dump_abort, any non-IDLE state: go IDLE, dmp_valid <= 0, no dump_done. This has priority over the handshake in the same cycle: the entry is not counted as transferred. wr_during_dump keeps its value.
- dump_req outside IDLE is ignored, not queued.
- wr_during_dump: set when dump_busy && rf_in_wre && rf_in_wa!=0. Cleared only by reset or an accepted dump_req.
- addr never wraps: the increment is suppressed at 31.

## Timing
- Reset: state IDLE, addr 0, rf_out_ra 0, dmp_valid 0, dmp_addr 0, dmp_data 0, dump_busy 0, dump_done 0, wr_during_dump 0. Reset mid-dump behaves like abort and also clears wr_during_dump.
- Edge numbering: dump_req is sampled at edge E0.
  - READ runs during the cycle after E0.
  - First dmp_valid rises after E1.
- With dmp_ready held 1, each entry costs 2 cycles. Entry k is valid after E(2k+1) and accepted at E(2k+2).
- SKIP_R0=1: 31 entries, last accepted at E62, dump_done high in the cycle after E62, IDLE after E63.
- SKIP_R0=0: 32 entries, last accepted at E64, dump_done after E64.
- Each cycle of dmp_ready low inside SEND adds exactly one cycle.
- dump_busy is high from after E0 through the DONE cycle.
- dump_done and dump_busy are both 1 in the DONE cycle.

## Test plan
- Full dump, SKIP_R0=1: preload rN=0x1000_0000+N, dmp_ready=1. Expect 31 entries r1..r31 with the matching data, dmp_last only on r31, dump_done one cycle after E62, wr_during_dump=0.
- Backpressure: dmp_ready low for 3 cycles while r5 is presented. Expect dmp_addr=5 and dmp_data stable; r6 is not issued early; dump_done is delayed by exactly 3 cycles.
- Bypass: a write r7<=0xDEADBEEF in the READ cycle for r7 yields dmp_data=0xDEADBEEF. A write to r3 during SEND of r3 leaves the held value unchanged. wr_during_dump=1.
- Abort: assert dump_abort while r10 is valid and dmp_ready=1. Expect IDLE next cycle, dmp_valid=0, no dump_done. A fresh dump_req restarts at r1.
- Ignored request and r0 write: pulse dump_req mid-dump; the sequence is unaffected. A write to r0 during the dump leaves wr_during_dump=0.
- Reset mid-dump: assert rst_l=1 during SEND of r20. All outputs take their reset values at the next edge, and a later dump runs normally.
